// File: rtl/timer_pkg.sv
// Shared types and helpers for the stopwatch input front-end:
// debounce FSM state encoding and a millisecond-to-cycles conversion.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_UP        = 2'd0,
        ST_WAIT_DOWN = 2'd1,
        ST_DOWN      = 2'd2,
        ST_WAIT_UP   = 2'd3
    } db_state_e;

    function automatic int unsigned cycles_from_ms(input int unsigned clk_hz,
                                                   input int unsigned ms);
        return (clk_hz / 32'd1000) * ms;
    endfunction

endpackage

// File: rtl/timer_input_conditioner_debouncer.sv
// Push-button synchroniser and debounce FSM producing a clean level plus press/release pulses.
// Optional long-press detection is built only when TIMER_LONG_PRESS_EN is defined.
module btn_debouncer
    import timer_pkg::*;
#(
    parameter int unsigned DB         = 1,
    parameter int unsigned LONG       = 1,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int unsigned     CW           = $clog2(DB + 1);
    localparam logic [CW-1:0]   DB_LAST      = CW'(DB - 1);
    localparam logic            RELEASED_RAW = ACTIVE_LOW;

    logic          sync1_q, sync2_q;
    logic          pressed_s;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Two-flop synchroniser, parked at the released level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RELEASED_RAW;
            sync2_q <= RELEASED_RAW;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = ACTIVE_LOW ? ~sync2_q : sync2_q;
    assign cnt_inc_s = cnt_q + CW'(1);

    // FSM state, stable-time counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_UP;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Next state: the entering sample counts as the first of DB stable samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_UP: begin
                if (pressed_s) begin
                    state_d = (DB_LAST == '0) ? ST_DOWN : ST_WAIT_DOWN;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_UP;
                end
            end
            ST_WAIT_DOWN: begin
                if (!pressed_s) begin
                    state_d = ST_UP;
                end else if (cnt_inc_s == DB_LAST) begin
                    state_d = ST_DOWN;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_DOWN: begin
                if (!pressed_s) begin
                    state_d = (DB_LAST == '0) ? ST_UP : ST_WAIT_UP;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_DOWN;
                end
            end
            ST_WAIT_UP: begin
                if (pressed_s) begin
                    state_d = ST_DOWN;
                end else if (cnt_inc_s == DB_LAST) begin
                    state_d = ST_UP;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = ST_UP;
                cnt_d   = '0;
            end
        endcase
    end

    // Pulses fire only on confirmed transitions; a WAIT_UP bounce back to DOWN is not a press.
    always_comb begin
        press_d   = ((state_q == ST_UP) || (state_q == ST_WAIT_DOWN)) && (state_d == ST_DOWN);
        release_d = ((state_q == ST_DOWN) || (state_q == ST_WAIT_UP)) && (state_d == ST_UP);
        level_d   = (state_d == ST_DOWN) || (state_d == ST_WAIT_UP);
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef TIMER_LONG_PRESS_EN
    localparam int unsigned   HW      = $clog2(LONG + 1);
    localparam logic [HW-1:0] LONG_V  = HW'(LONG);
    localparam logic [HW-1:0] LONG_M1 = HW'(LONG - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Hold counter saturates at LONG so the pulse fires once per hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    // Cleared only on reaching UP; frozen in WAIT_UP so a bounce keeps the count.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_d == ST_UP) begin
            hold_d = '0;
        end else if ((state_q == ST_DOWN) && (hold_q != LONG_V)) begin
            hold_d = hold_q + HW'(1);
            long_d = (hold_q == LONG_M1);
        end else begin
            hold_d = hold_q;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/timer_input_conditioner.sv
// Stopwatch front-end: clock divider tick plus debounced stop button.
// Define TIMER_LONG_PRESS_EN to enable the btn_long long-press pulse.
module timer_input_conditioner
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned TICK_HZ        = 1,
    parameter int unsigned DEBOUNCE_MS    = 20,
    parameter bit          BTN_ACTIVE_LOW = 1'b1,
    parameter int unsigned LONG_MS        = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic tick,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int unsigned   DIV      = CLK_HZ / TICK_HZ;
    localparam int unsigned   DB       = cycles_from_ms(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned   LONG     = cycles_from_ms(CLK_HZ, LONG_MS);
    localparam int unsigned   DW       = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          tick_q, tick_d;

    // Divider state and registered tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
        end
    end

    // Wrap at DIV-1; the tick lands as the counter returns to zero.
    always_comb begin
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            tick_d    = 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
            tick_d    = 1'b0;
        end
    end

    assign tick = tick_q;

    btn_debouncer #(
        .DB         (DB),
        .LONG       (LONG),
        .ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_debouncer (
        .clk       (clk),
        .reset     (reset),
        .btn_raw_i (btn_raw),
        .level_o   (btn_level),
        .press_o   (btn_press),
        .release_o (btn_release),
        .long_o    (btn_long)
    );

endmodule

// File: tb/tb_timer_input_conditioner.sv
// Directed bench for timer_input_conditioner with DIV=10, DB=5, LONG=20.
module tb_timer_input_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic btn_raw;
    logic tick, btn_level, btn_press, btn_release, btn_long;

    int checks = 0;
    int fails  = 0;

    timer_input_conditioner #(
        .CLK_HZ         (1000),
        .TICK_HZ        (100),
        .DEBOUNCE_MS    (5),
        .BTN_ACTIVE_LOW (1'b1),
        .LONG_MS        (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .tick        (tick),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        btn_raw = 1'b1;
        repeat (3) step();
        checks += 5;
        if (tick !== 1'b0)        begin fails++; $display("FAIL reset_tick got %b expected 0", tick); end
        if (btn_level !== 1'b0)   begin fails++; $display("FAIL reset_level got %b expected 0", btn_level); end
        if (btn_press !== 1'b0)   begin fails++; $display("FAIL reset_press got %b expected 0", btn_press); end
        if (btn_release !== 1'b0) begin fails++; $display("FAIL reset_release got %b expected 0", btn_release); end
        if (btn_long !== 1'b0)    begin fails++; $display("FAIL reset_long got %b expected 0", btn_long); end
    endtask

    // Released button: tick on cycles 10, 20, 30 after reset release, no button activity.
    task automatic test_tick();
        reset = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            step();
            checks += 3;
            if (tick !== ((c % 10) == 0)) begin
                fails++; $display("FAIL tick cycle %0d got %b expected %b", c, tick, ((c % 10) == 0));
            end
            if (btn_press !== 1'b0) begin
                fails++; $display("FAIL tick_no_press cycle %0d got %b expected 0", c, btn_press);
            end
            if (btn_level !== 1'b0) begin
                fails++; $display("FAIL tick_no_level cycle %0d got %b expected 0", c, btn_level);
            end
        end
    endtask

    // Clean press: btn_press 7 cycles after the edge, then hold to 20 cycles.
    task automatic test_press();
        btn_raw = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            checks += 3;
            if (btn_press !== (c == 7)) begin
                fails++; $display("FAIL press cycle %0d got %b expected %b", c, btn_press, (c == 7));
            end
            if (btn_level !== (c >= 7)) begin
                fails++; $display("FAIL press_level cycle %0d got %b expected %b", c, btn_level, (c >= 7));
            end
            if (btn_release !== 1'b0) begin
                fails++; $display("FAIL press_no_release cycle %0d got %b expected 0", c, btn_release);
            end
        end
    endtask

    task automatic test_release();
        btn_raw = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            checks += 3;
            if (btn_release !== (c == 7)) begin
                fails++; $display("FAIL release cycle %0d got %b expected %b", c, btn_release, (c == 7));
            end
            if (btn_level !== (c < 7)) begin
                fails++; $display("FAIL release_level cycle %0d got %b expected %b", c, btn_level, (c < 7));
            end
            if (btn_press !== 1'b0) begin
                fails++; $display("FAIL release_no_press cycle %0d got %b expected 0", c, btn_press);
            end
        end
    endtask

    // Bounce every 2 cycles never reaches 5 stable samples.
    task automatic test_bounce();
        for (int c = 0; c < 40; c++) begin
            btn_raw = (c < 30) ? (((c / 2) % 2) != 0) : 1'b1;
            step();
            checks += 3;
            if (btn_press !== 1'b0) begin
                fails++; $display("FAIL bounce_press cycle %0d got %b expected 0", c, btn_press);
            end
            if (btn_release !== 1'b0) begin
                fails++; $display("FAIL bounce_release cycle %0d got %b expected 0", c, btn_release);
            end
            if (btn_level !== 1'b0) begin
                fails++; $display("FAIL bounce_level cycle %0d got %b expected 0", c, btn_level);
            end
        end
    endtask

    // Reset 3 cycles into WAIT_DOWN aborts; held button re-presses 7 cycles after reset.
    task automatic test_reset_mid_debounce();
        btn_raw = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            checks += 1;
            if (btn_press !== 1'b0) begin
                fails++; $display("FAIL abort_pre_press cycle %0d got %b expected 0", c, btn_press);
            end
        end
        reset = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks += 2;
            if (btn_press !== 1'b0) begin
                fails++; $display("FAIL abort_press cycle %0d got %b expected 0", c, btn_press);
            end
            if (btn_level !== 1'b0) begin
                fails++; $display("FAIL abort_level cycle %0d got %b expected 0", c, btn_level);
            end
        end
        reset = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            checks += 3;
            if (btn_press !== (c == 7)) begin
                fails++; $display("FAIL held_press cycle %0d got %b expected %b", c, btn_press, (c == 7));
            end
            if (btn_level !== (c >= 7)) begin
                fails++; $display("FAIL held_level cycle %0d got %b expected %b", c, btn_level, (c >= 7));
            end
            if (tick !== (c == 10)) begin
                fails++; $display("FAIL held_tick cycle %0d got %b expected %b", c, tick, (c == 10));
            end
        end
    endtask

    // Continues the hold begun above (press on cycle 7); long pulse 20 cycles later, once.
    task automatic test_long_press();
        logic exp_long;
        for (int c = 11; c <= 50; c++) begin
            step();
`ifdef TIMER_LONG_PRESS_EN
            exp_long = (c == 27);
`else
            exp_long = 1'b0;
`endif
            checks += 2;
            if (btn_long !== exp_long) begin
                fails++; $display("FAIL long cycle %0d got %b expected %b", c, btn_long, exp_long);
            end
            if (btn_press !== 1'b0) begin
                fails++; $display("FAIL long_no_press cycle %0d got %b expected 0", c, btn_press);
            end
        end
        btn_raw = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            checks += 2;
            if (btn_release !== (c == 7)) begin
                fails++; $display("FAIL long_release cycle %0d got %b expected %b", c, btn_release, (c == 7));
            end
            if (btn_long !== 1'b0) begin
                fails++; $display("FAIL long_after_release cycle %0d got %b expected 0", c, btn_long);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_press();
        test_release();
        test_bounce();
        test_reset_mid_debounce();
        test_long_press();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
